// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared types and constants for the up/down sweep sequencer.
package updown_pkg;

  localparam int W      = 7;
  localparam int NCYC_W = 8;
  localparam int STEP_W = 4;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_UP,
    S_DOWN,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [W-1:0]      lo;
    logic [W-1:0]      hi;
    logic [STEP_W-1:0] up_step;
    logic [STEP_W-1:0] dn_step;
    logic [NCYC_W-1:0] ncyc;
  } cfg_t;

  function automatic logic cfg_legal(input cfg_t c);
    return (c.lo < c.hi) && (c.up_step != '0) && (c.dn_step != '0);
  endfunction

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Host-side config/control and counter-consumer signals of the sweep sequencer.
interface updown_sweep_ctrl_if;
  import updown_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [W-1:0]      cfg_lo;
  logic [W-1:0]      cfg_hi;
  logic [STEP_W-1:0] cfg_up_step;
  logic [STEP_W-1:0] cfg_dn_step;
  logic [NCYC_W-1:0] cfg_ncyc;
  logic              start;
  logic              stop;
  logic              pause;
  logic [W-1:0]      cnt;
  logic              dir;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cfg_valid, cfg_lo, cfg_hi, cfg_up_step, cfg_dn_step, cfg_ncyc,
    output start, stop, pause,
    input  cfg_ready, cnt, dir, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_lo, cfg_hi, cfg_up_step, cfg_dn_step, cfg_ncyc,
    input  start, stop, pause,
    output cfg_ready, cnt, dir, busy, done, err
  );

endinterface

// File: rtl/updown_sweep_ctrl_step_dp.sv
// Next-count datapath: one up or down step with clamping at the bounds.
module updown_step_dp
  import updown_pkg::*;
(
  input  logic [W-1:0]      cnt,
  input  logic [W-1:0]      lo,
  input  logic [W-1:0]      hi,
  input  logic [STEP_W-1:0] up_step,
  input  logic [STEP_W-1:0] dn_step,
  input  logic              dir,
  output logic [W-1:0]      cnt_nxt,
  output logic              hit_hi,
  output logic              hit_lo
);

  logic [W:0]        sum;
  logic signed [W:0] diff;

  // One extra bit keeps the overshoot past hi and the undershoot below 0 visible.
  assign sum    = {1'b0, cnt} + {{(W+1-STEP_W){1'b0}}, up_step};
  assign diff   = $signed({1'b0, cnt}) - $signed({{(W+1-STEP_W){1'b0}}, dn_step});
  assign hit_hi = sum >= {1'b0, hi};
  assign hit_lo = diff <= $signed({1'b0, lo});

  always_comb begin
    cnt_nxt = '0;
    if (dir == DIR_DN) cnt_nxt = hit_lo ? lo : diff[W-1:0];
    else               cnt_nxt = hit_hi ? hi : sum[W-1:0];
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer: config handshake, lo->hi->lo bounce FSM and bounce counting.
// Optional pause support is built when UPDOWN_SWEEP_PAUSE_EN is defined.
//
//   state    | meaning
//   S_IDLE   | no config held
//   S_READY  | config held, waiting for start
//   S_UP     | stepping up toward hi
//   S_DOWN   | stepping down toward lo
//   S_FINISH | one-cycle done pulse, cnt parked at lo
module updown_sweep_ctrl
  import updown_pkg::*;
(
  input logic                clk,
  input logic                rst,
  updown_sweep_ctrl_if.slave bus
);

  state_t            state;
  cfg_t              cfg_q;
  cfg_t              cfg_in;
  logic [W-1:0]      cnt_q;
  logic              dir_q;
  logic              err_q;
  logic [NCYC_W-1:0] bounce_q;
  logic [NCYC_W-1:0] bounce_nxt;
  logic [W-1:0]      cnt_nxt;
  logic              hit_hi;
  logic              hit_lo;
  logic              ready;
  logic              xfer;
  logic              freeze;

`ifdef UPDOWN_SWEEP_PAUSE_EN
  assign freeze = bus.pause;
`else
  assign freeze = 1'b0;
`endif

  assign cfg_in     = {bus.cfg_lo, bus.cfg_hi, bus.cfg_up_step, bus.cfg_dn_step, bus.cfg_ncyc};
  assign ready      = (state == S_IDLE) || (state == S_READY);
  assign xfer       = bus.cfg_valid && ready;
  assign bounce_nxt = bounce_q + 1'b1;

  assign bus.cfg_ready = ready;
  assign bus.cnt       = cnt_q;
  assign bus.dir       = dir_q;
  assign bus.busy      = (state == S_UP) || (state == S_DOWN);
  assign bus.done      = (state == S_FINISH);
  assign bus.err       = err_q;

  updown_step_dp u_step_dp (
    .cnt     (cnt_q),
    .lo      (cfg_q.lo),
    .hi      (cfg_q.hi),
    .up_step (cfg_q.up_step),
    .dn_step (cfg_q.dn_step),
    .dir     (dir_q),
    .cnt_nxt (cnt_nxt),
    .hit_hi  (hit_hi),
    .hit_lo  (hit_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cfg_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      err_q    <= 1'b0;
      bounce_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          // A config transfer pre-empts a start seen in the same cycle.
          if (xfer) begin
            if (cfg_legal(cfg_in)) begin
              cfg_q <= cfg_in;
              err_q <= 1'b0;
              state <= S_READY;
            end else begin
              err_q <= 1'b1;
            end
          end else if (state == S_READY && bus.start) begin
            cnt_q    <= cfg_q.lo;
            dir_q    <= DIR_UP;
            bounce_q <= '0;
            state    <= S_UP;
          end
        end
        S_UP: begin
          if (bus.stop) begin
            state <= S_READY;
          end else if (!freeze) begin
            cnt_q <= cnt_nxt;
            if (hit_hi) begin
              dir_q <= DIR_DN;
              state <= S_DOWN;
            end
          end
        end
        S_DOWN: begin
          if (bus.stop) begin
            state <= S_READY;
          end else if (!freeze) begin
            cnt_q <= cnt_nxt;
            if (hit_lo) begin
              bounce_q <= bounce_nxt;
              if (cfg_q.ncyc != '0 && bounce_nxt == cfg_q.ncyc) begin
                state <= S_FINISH;
              end else begin
                dir_q <= DIR_UP;
                state <= S_UP;
              end
            end
          end
        end
        S_FINISH: begin
          dir_q <= DIR_UP;
          state <= S_READY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed scoreboard bench for updown_sweep_ctrl; expectations are tagged with the cycle they apply to.
module tb_updown_sweep_ctrl;
  import updown_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  updown_sweep_ctrl_if bus();

  updown_sweep_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0]  cyc;
    logic [W-1:0] cnt;
    logic         dir;
    logic         busy;
    logic         done;
    logic         err;
    logic         rdy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input int c, input logic d, input logic b,
                              input logic dn, input logic e, input logic r);
    exp_t x;
    x.cyc  = '0;
    x.cnt  = W'(c);
    x.dir  = d;
    x.busy = b;
    x.done = dn;
    x.err  = e;
    x.rdy  = r;
    return x;
  endfunction

  task automatic cmp(input string tag, input exp_t e);
    vectors++;
    if (bus.cnt !== e.cnt || bus.dir !== e.dir || bus.busy !== e.busy ||
        bus.done !== e.done || bus.err !== e.err || bus.cfg_ready !== e.rdy) begin
      miscompares++;
      $display("FAIL %s cyc %0d: got cnt=%0d dir=%0b busy=%0b done=%0b err=%0b rdy=%0b, want cnt=%0d dir=%0b busy=%0b done=%0b err=%0b rdy=%0b",
               tag, cyc, bus.cnt, bus.dir, bus.busy, bus.done, bus.err, bus.cfg_ready,
               e.cnt, e.dir, e.busy, e.done, e.err, e.rdy);
    end
  endtask

  // Monitor: compare every expectation in the cycle it was tagged for.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string t;
    while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (int'(e.cyc) < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: expectation for cyc %0d missed, now cyc %0d", t, e.cyc, cyc);
      end else begin
        cmp(t, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input int c, input logic d, input logic b,
                      input logic dn, input logic e, input logic r);
    exp_t x;
    x = mk(c, d, b, dn, e, r);
    x.cyc = 32'(cyc + 1);
    exp_q.push_back(x);
    tag_q.push_back(tag);
    tick();
  endtask

  task automatic set_cfg(input int lo, input int hi, input int up, input int dn, input int nc);
    bus.cfg_lo      = W'(lo);
    bus.cfg_hi      = W'(hi);
    bus.cfg_up_step = STEP_W'(up);
    bus.cfg_dn_step = STEP_W'(dn);
    bus.cfg_ncyc    = NCYC_W'(nc);
  endtask

  initial begin
    int clamp_cnt[10] = '{7, 10, 7, 4, 3, 7, 10, 7, 4, 3};
    int clamp_dir[10] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    int seq6[10]      = '{23, 26, 29, 30, 28, 26, 24, 22, 20, 20};
    int last;

    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.pause     = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

    repeat (2) tick();
    cmp("reset_defaults", mk(0, 0, 0, 0, 0, 1));
    rst = 1'b0;
    step("idle_after_reset", 0, 0, 0, 0, 0, 1);

    // Long sweep, single bounce.
    set_cfg(0, 100, 2, 1, 1);
    bus.cfg_valid = 1'b1;
    step("cfg1", 0, 0, 0, 0, 0, 1);
    bus.cfg_valid = 1'b0;
    bus.start = 1'b1;
    step("start1", 0, 0, 1, 0, 0, 0);
    bus.start = 1'b0;
    for (int k = 1; k <= 50; k++) step("sweep1_up", 2 * k, (k == 50), 1, 0, 0, 0);
    for (int j = 1; j < 100; j++) step("sweep1_dn", 100 - j, 1, 1, 0, 0, 0);
    step("sweep1_done", 0, 1, 0, 1, 0, 0);
    step("sweep1_ready", 0, 0, 0, 0, 0, 1);
    step("sweep1_no_redone", 0, 0, 0, 0, 0, 1);

    // Clamping at both bounds, two bounces.
    set_cfg(3, 10, 4, 3, 2);
    bus.cfg_valid = 1'b1;
    step("cfg2", 0, 0, 0, 0, 0, 1);
    bus.cfg_valid = 1'b0;
    bus.start = 1'b1;
    step("start2", 3, 0, 1, 0, 0, 0);
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) step("clamp_seq", clamp_cnt[i], clamp_dir[i][0], 1, 0, 0, 0);
    step("clamp_done", 3, 1, 0, 1, 0, 0);
    step("clamp_ready", 3, 0, 0, 0, 0, 1);

    // Illegal config from IDLE, then a legal one.
    @(negedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    set_cfg(5, 5, 1, 1, 0);
    bus.cfg_valid = 1'b1;
    step("illegal_cfg", 0, 0, 0, 0, 1, 1);
    bus.cfg_valid = 1'b0;
    bus.start = 1'b1;
    step("start_in_idle", 0, 0, 0, 0, 1, 1);
    bus.start = 1'b0;
    set_cfg(10, 60, 5, 5, 0);
    bus.cfg_valid = 1'b1;
    step("legal_clears_err", 0, 0, 0, 0, 0, 1);
    bus.cfg_valid = 1'b0;

    // Stop mid-UP, then restart from lo.
    bus.start = 1'b1;
    step("start5", 10, 0, 1, 0, 0, 0);
    bus.start = 1'b0;
    for (int k = 1; k <= 6; k++) step("up5", 10 + 5 * k, 0, 1, 0, 0, 0);
    bus.stop = 1'b1;
    step("stop_at_40", 40, 0, 0, 0, 0, 1);
    bus.stop = 1'b0;
    repeat (3) step("stop_hold", 40, 0, 0, 0, 0, 1);
    bus.start = 1'b1;
    step("restart", 10, 0, 1, 0, 0, 0);
    bus.start = 1'b0;
    step("restart_step", 15, 0, 1, 0, 0, 0);
    bus.stop = 1'b1;
    step("stop_again", 15, 0, 0, 0, 0, 1);
    bus.stop = 1'b0;

    // Config and start together: config wins.
    set_cfg(20, 30, 3, 2, 1);
    bus.cfg_valid = 1'b1;
    bus.start = 1'b1;
    step("cfg_beats_start", 15, 0, 0, 0, 0, 1);
    bus.cfg_valid = 1'b0;
    step("start_new_bounds", 20, 0, 1, 0, 0, 0);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) step("sweep6", seq6[i], (i >= 3), 1, 0, 0, 0);
    step("sweep6_done", 20, 1, 0, 1, 0, 0);
    step("sweep6_ready", 20, 0, 0, 0, 0, 1);

    // Pause at cnt=20 (free-run config).
    set_cfg(0, 100, 2, 1, 0);
    bus.cfg_valid = 1'b1;
    step("cfg7", 20, 0, 0, 0, 0, 1);
    bus.cfg_valid = 1'b0;
    bus.start = 1'b1;
    step("start7", 0, 0, 1, 0, 0, 0);
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) step("up7", 2 * k, 0, 1, 0, 0, 0);
    bus.pause = 1'b1;
`ifdef UPDOWN_SWEEP_PAUSE_EN
    for (int i = 0; i < 3; i++) step("pause_hold", 20, 0, 1, 0, 0, 0);
    bus.pause = 1'b0;
    step("pause_resume", 22, 0, 1, 0, 0, 0);
    last = 22;
`else
    for (int i = 0; i < 3; i++) step("pause_ignored", 22 + 2 * i, 0, 1, 0, 0, 0);
    bus.pause = 1'b0;
    step("pause_after", 28, 0, 1, 0, 0, 0);
    last = 28;
`endif
    bus.stop = 1'b1;
    step("stop7", last, 0, 0, 0, 0, 1);
    bus.stop = 1'b0;

    // Async reset mid-DOWN.
    bus.start = 1'b1;
    step("start8", 0, 0, 1, 0, 0, 0);
    bus.start = 1'b0;
    for (int k = 1; k <= 50; k++) step("up8", 2 * k, (k == 50), 1, 0, 0, 0);
    for (int j = 1; j <= 5; j++) step("dn8", 100 - j, 1, 1, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 cmp("async_rst", mk(0, 0, 0, 0, 0, 1));
    tick();
    tick();
    rst = 1'b0;
    bus.start = 1'b1;
    step("cfg_lost_after_rst", 0, 0, 0, 0, 0, 1);
    bus.start = 1'b0;

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
